axi_burst_bridge: RTL and testbench



---
 rtl/axi_burst_bridge_pkg.sv | 12 +
 rtl/axi_burst_bridge_arb.sv | 36 +++
 rtl/axi_burst_bridge.sv | 154 +++++++++++++++
 tb/tb_axi_burst_bridge.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_bridge_pkg.sv
// axi_pkg: shared AXI constants, bridge state encoding and write-strobe helper
// Contents: AXI_BURST_INCR, SZ_BYTE/SZ_HALF/SZ_WORD, state_t, wstrb_of()
package axi_pkg;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    typedef enum logic [2:0] {IDLE, AR, R, WR, B} state_t;
    function automatic logic [3:0] wstrb_of(input logic [1:0] size, input logic [1:0] off);
        return size == SZ_BYTE ? 4'b0001 << off : size == SZ_HALF ? 4'b0011 << off : 4'b1111;
    endfunction
endpackage

// File: rtl/axi_burst_bridge_arb.sv
// rr_arbiter: round-robin one-hot grant, search starts one past the last accepted grant
// Ports: clk, rst, req[N], adv (grant accepted), grant[N] one-hot, idx (granted index)
module rr_arbiter #(
    parameter int N = 2,
    localparam int W = N > 1 ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx
);
    logic [W-1:0] ptr_q, ptr_d;
    logic found;
    int j;
    always_comb begin
        grant = '0;
        idx = '0;
        found = 1'b0;
        j = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr_q) + i) % N;
            if (!found && req[j]) begin
                found = 1'b1;
                grant[j] = 1'b1;
                idx = W'(j);
            end
        end
        ptr_d = adv && found ? (int'(idx) == N - 1 ? '0 : idx + 1'b1) : ptr_q;
    end
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else ptr_q <= ptr_d;
    end
endmodule

// File: rtl/axi_burst_bridge.sv
// axi_burst_bridge: round-robin bridge from NUM_PORTS sram-like masters to one AXI3 master
// Ports: clk/rst; p_* sram-like request/response per port (packed per port index);
//        ar/r/aw/w/b AXI3 master channels (ID = port index); axi_err sticky on nonzero resp
module axi_burst_bridge
    import axi_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int LINE_WORDS = 8,
    parameter int ID_W       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PORTS-1:0]    p_req,
    input  logic [NUM_PORTS-1:0]    p_wr,
    input  logic [NUM_PORTS-1:0]    p_burst,
    input  logic [2*NUM_PORTS-1:0]  p_size,
    input  logic [32*NUM_PORTS-1:0] p_addr,
    input  logic [32*NUM_PORTS-1:0] p_wdata,
    output logic [31:0]             p_rdata,
    output logic [NUM_PORTS-1:0]    p_addr_ok,
    output logic [NUM_PORTS-1:0]    p_data_ok,
    output logic [ID_W-1:0]         arid,
    output logic [31:0]             araddr,
    output logic [3:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [1:0]              arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [ID_W-1:0]         rid,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [ID_W-1:0]         awid,
    output logic [31:0]             awaddr,
    output logic [3:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [1:0]              awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ID_W-1:0]         wid,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [ID_W-1:0]         bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic                    axi_err
);
    localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
    localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);
    state_t state_q, state_d;
    logic wr_q, wr_d, burst_q, burst_d, aw_done_q, aw_done_d, w_done_q, w_done_d, axi_err_q, axi_err_d;
    logic [1:0] size_q, size_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [PW-1:0] gnt_q, gnt_d, gidx;
    logic [NUM_PORTS-1:0] grant;
    logic adv, unused_ids;
    assign adv = state_q == IDLE && |p_req;
    assign unused_ids = ^{rid, bid};
    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .clk(clk), .rst(rst), .req(p_req), .adv(adv), .grant(grant), .idx(gidx)
    );
    always_comb begin
        state_d = state_q;
        wr_d = wr_q;
        burst_d = burst_q;
        size_d = size_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        gnt_d = gnt_q;
        // done flags only live inside WR so each WR entry starts with both channels pending
        aw_done_d = state_q == WR && (aw_done_q || (awvalid && awready));
        w_done_d = state_q == WR && (w_done_q || (wvalid && wready));
        axi_err_d = axi_err_q | (rvalid && rready && |rresp) | (bvalid && bready && |bresp);
        if (adv) begin
            wr_d = p_wr[gidx];
            burst_d = p_burst[gidx];
            size_d = p_size[2*gidx +: 2];
            addr_d = p_addr[32*gidx +: 32];
            wdata_d = p_wdata[32*gidx +: 32];
            gnt_d = gidx;
            state_d = p_wr[gidx] ? WR : AR;
        end
        else if (state_q == AR && arready) state_d = R;
        else if (state_q == R && rvalid && rlast) state_d = IDLE;
        else if (state_q == WR && aw_done_d && w_done_d) state_d = B;
        else if (state_q == B && bvalid) state_d = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q <= 1'b0;
            burst_q <= 1'b0;
            size_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            gnt_q <= '0;
            aw_done_q <= 1'b0;
            w_done_q <= 1'b0;
            axi_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q <= wr_d;
            burst_q <= burst_d;
            size_q <= size_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            gnt_q <= gnt_d;
            aw_done_q <= aw_done_d;
            w_done_q <= w_done_d;
            axi_err_q <= axi_err_d;
        end
    end
    assign p_addr_ok = adv ? grant : '0;
    assign p_data_ok = (state_q == R && rvalid) || (state_q == B && bvalid) ? NUM_PORTS'(1) << gnt_q : '0;
    assign p_rdata = rdata;
    assign arid = ID_W'(gnt_q);
    assign araddr = burst_q ? addr_q & ~LINE_MASK : addr_q;
    assign arlen = burst_q ? 4'(LINE_WORDS - 1) : 4'd0;
    assign arsize = {1'b0, size_q};
    assign arburst = AXI_BURST_INCR;
    assign arlock = 2'b0;
    assign arcache = 4'b0;
    assign arprot = 3'b0;
    assign arvalid = state_q == AR;
    assign rready = state_q == R;
    assign awid = ID_W'(gnt_q);
    assign awaddr = addr_q;
    assign awlen = 4'd0;
    assign awsize = {1'b0, size_q};
    assign awburst = AXI_BURST_INCR;
    assign awlock = 2'b0;
    assign awcache = 4'b0;
    assign awprot = 3'b0;
    assign awvalid = state_q == WR && !aw_done_q;
    assign wid = ID_W'(gnt_q);
    assign wdata = wdata_q;
    assign wstrb = wstrb_of(size_q, addr_q[1:0]);
    assign wlast = 1'b1;
    assign wvalid = state_q == WR && !w_done_q;
    assign bready = state_q == B;
    assign axi_err = axi_err_q;
endmodule

// File: tb/tb_axi_burst_bridge.sv
// tb_axi_burst_bridge: directed self-checking bench for axi_burst_bridge (2 ports, 8-word lines)
module tb_axi_burst_bridge;
    localparam int NP = 2, LW = 8, IW = 4;
    logic clk = 1'b0, rst;
    logic [NP-1:0] p_req, p_wr, p_burst, p_addr_ok, p_data_ok;
    logic [2*NP-1:0] p_size;
    logic [32*NP-1:0] p_addr, p_wdata;
    logic [31:0] p_rdata, araddr, rdata, awaddr, wdata;
    logic [IW-1:0] arid, rid, awid, wid, bid;
    logic [3:0] arlen, arcache, awlen, awcache, wstrb;
    logic [2:0] arsize, arprot, awsize, awprot;
    logic [1:0] arburst, arlock, rresp, awburst, awlock, bresp;
    logic arvalid, arready, rlast, rvalid, rready, awvalid, awready, wlast, wvalid, wready, bvalid, bready, axi_err;
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    axi_burst_bridge #(.NUM_PORTS(NP), .LINE_WORDS(LW), .ID_W(IW)) dut (
        .clk(clk), .rst(rst), .p_req(p_req), .p_wr(p_wr), .p_burst(p_burst), .p_size(p_size),
        .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(p_rdata), .p_addr_ok(p_addr_ok), .p_data_ok(p_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready), .axi_err(axi_err)
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        #1;
        total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid got=%b exp=0", arvalid); end
        total++; if (rready !== 1'b0) begin bad++; $display("FAIL rst_rready got=%b exp=0", rready); end
        total++; if (awvalid !== 1'b0) begin bad++; $display("FAIL rst_awvalid got=%b exp=0", awvalid); end
        total++; if (wvalid !== 1'b0) begin bad++; $display("FAIL rst_wvalid got=%b exp=0", wvalid); end
        total++; if (bready !== 1'b0) begin bad++; $display("FAIL rst_bready got=%b exp=0", bready); end
        total++; if (p_addr_ok !== 2'b00) begin bad++; $display("FAIL rst_addr_ok got=%b exp=00", p_addr_ok); end
        total++; if (p_data_ok !== 2'b00) begin bad++; $display("FAIL rst_data_ok got=%b exp=00", p_data_ok); end
        total++; if (axi_err !== 1'b0) begin bad++; $display("FAIL rst_axi_err got=%b exp=0", axi_err); end
    endtask
    task automatic test_single_read;
        tick;
        p_req = 2'b01; p_wr = 2'b00; p_burst = 2'b00; p_size = 4'b1010; p_addr[31:0] = 32'h1FC0_0004;
        #1;
        total++; if (p_addr_ok !== 2'b01) begin bad++; $display("FAIL sr_addr_ok got=%b exp=01", p_addr_ok); end
        tick;
        p_req = 2'b00;
        #1;
        total++; if (arvalid !== 1'b1) begin bad++; $display("FAIL sr_arvalid got=%b exp=1", arvalid); end
        total++; if (araddr !== 32'h1FC0_0004) begin bad++; $display("FAIL sr_araddr got=%h exp=1fc00004", araddr); end
        total++; if (arlen !== 4'd0) begin bad++; $display("FAIL sr_arlen got=%0d exp=0", arlen); end
        total++; if (arsize !== 3'd2) begin bad++; $display("FAIL sr_arsize got=%0d exp=2", arsize); end
        total++; if (arid !== 4'd0) begin bad++; $display("FAIL sr_arid got=%0d exp=0", arid); end
        total++; if (arburst !== 2'b01) begin bad++; $display("FAIL sr_arburst got=%b exp=01", arburst); end
        total++; if (p_addr_ok !== 2'b00) begin bad++; $display("FAIL sr_addr_ok_ar got=%b exp=00", p_addr_ok); end
        arready = 1'b1;
        tick;
        arready = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rlast = 1'b1; rresp = 2'b00;
        #1;
        total++; if (p_data_ok !== 2'b01) begin bad++; $display("FAIL sr_data_ok got=%b exp=01", p_data_ok); end
        total++; if (p_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sr_rdata got=%h exp=deadbeef", p_rdata); end
        tick;
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        total++; if (p_data_ok !== 2'b00) begin bad++; $display("FAIL sr_data_ok_after got=%b exp=00", p_data_ok); end
        total++; if (rready !== 1'b0) begin bad++; $display("FAIL sr_idle_rready got=%b exp=0", rready); end
    endtask
    task automatic test_burst_read;
        int n = 0;
        tick;
        p_req = 2'b10; p_wr = 2'b00; p_burst = 2'b10; p_size = 4'b1010; p_addr[63:32] = 32'h0000_1014;
        #1;
        total++; if (p_addr_ok !== 2'b10) begin bad++; $display("FAIL br_addr_ok got=%b exp=10", p_addr_ok); end
        tick;
        p_req = 2'b00;
        #1;
        total++; if (araddr !== 32'h0000_1000) begin bad++; $display("FAIL br_araddr got=%h exp=00001000", araddr); end
        total++; if (arlen !== 4'd7) begin bad++; $display("FAIL br_arlen got=%0d exp=7", arlen); end
        total++; if (arid !== 4'd1) begin bad++; $display("FAIL br_arid got=%0d exp=1", arid); end
        arready = 1'b1;
        tick;
        arready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k % 3 == 1) begin
                rvalid = 1'b0;
                #1;
                total++; if (p_data_ok !== 2'b00) begin bad++; $display("FAIL br_gap%0d got=%b exp=00", k, p_data_ok); end
                tick;
            end
            rvalid = 1'b1; rdata = k; rlast = k == 7;
            #1;
            total++; if (p_data_ok !== 2'b10) begin bad++; $display("FAIL br_beat%0d_ok got=%b exp=10", k, p_data_ok); end
            total++; if (p_rdata !== 32'(k)) begin bad++; $display("FAIL br_beat%0d_data got=%h exp=%h", k, p_rdata, k); end
            if (p_data_ok[1]) n++;
            tick;
        end
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        total++; if (n != 8) begin bad++; $display("FAIL br_pulses got=%0d exp=8", n); end
        total++; if (rready !== 1'b0) begin bad++; $display("FAIL br_idle_rready got=%b exp=0", rready); end
        p_burst = 2'b00;
    endtask
    task automatic test_write;
        tick;
        p_req = 2'b01; p_wr = 2'b01; p_size = 4'b1000; p_addr[31:0] = 32'h0000_2003; p_wdata[31:0] = 32'hAB00_0000;
        #1;
        total++; if (p_addr_ok !== 2'b01) begin bad++; $display("FAIL wb_addr_ok got=%b exp=01", p_addr_ok); end
        tick;
        p_req = 2'b00;
        #1;
        total++; if ({awvalid, wvalid} !== 2'b11) begin bad++; $display("FAIL wb_valids got=%b exp=11", {awvalid, wvalid}); end
        total++; if (wstrb !== 4'b1000) begin bad++; $display("FAIL wb_wstrb got=%b exp=1000", wstrb); end
        total++; if (awaddr !== 32'h0000_2003) begin bad++; $display("FAIL wb_awaddr got=%h exp=00002003", awaddr); end
        total++; if ({awlen, wlast} !== 5'b00001) begin bad++; $display("FAIL wb_len_last got=%b exp=00001", {awlen, wlast}); end
        total++; if (wdata !== 32'hAB00_0000) begin bad++; $display("FAIL wb_wdata got=%h exp=ab000000", wdata); end
        wready = 1'b1;
        tick;
        wready = 1'b0;
        #1;
        total++; if ({awvalid, wvalid} !== 2'b10) begin bad++; $display("FAIL wb_w_dropped got=%b exp=10", {awvalid, wvalid}); end
        total++; if (p_data_ok !== 2'b00) begin bad++; $display("FAIL wb_early_ok got=%b exp=00", p_data_ok); end
        tick;
        tick;
        awready = 1'b1;
        #1;
        total++; if ({awvalid, bready} !== 2'b10) begin bad++; $display("FAIL wb_aw_held got=%b exp=10", {awvalid, bready}); end
        tick;
        awready = 1'b0;
        #1;
        total++; if ({awvalid, bready} !== 2'b01) begin bad++; $display("FAIL wb_in_b got=%b exp=01", {awvalid, bready}); end
        total++; if (p_data_ok !== 2'b00) begin bad++; $display("FAIL wb_ok_before_b got=%b exp=00", p_data_ok); end
        tick;
        bvalid = 1'b1; bresp = 2'b00;
        #1;
        total++; if (p_data_ok !== 2'b01) begin bad++; $display("FAIL wb_data_ok got=%b exp=01", p_data_ok); end
        tick;
        bvalid = 1'b0;
        #1;
        total++; if (bready !== 1'b0) begin bad++; $display("FAIL wb_idle_bready got=%b exp=0", bready); end
        p_req = 2'b10; p_wr = 2'b10; p_size = 4'b0100; p_addr[63:32] = 32'h0000_2002; p_wdata[63:32] = 32'h1234_0000;
        #1;
        total++; if (p_addr_ok !== 2'b10) begin bad++; $display("FAIL wh_addr_ok got=%b exp=10", p_addr_ok); end
        tick;
        p_req = 2'b00;
        #1;
        total++; if (wstrb !== 4'b1100) begin bad++; $display("FAIL wh_wstrb got=%b exp=1100", wstrb); end
        total++; if ({awid, wid} !== 8'h11) begin bad++; $display("FAIL wh_ids got=%h exp=11", {awid, wid}); end
        awready = 1'b1; wready = 1'b1;
        tick;
        awready = 1'b0; wready = 1'b0;
        #1;
        total++; if ({awvalid, wvalid, bready} !== 3'b001) begin bad++; $display("FAIL wh_in_b got=%b exp=001", {awvalid, wvalid, bready}); end
        total++; if (p_data_ok !== 2'b00) begin bad++; $display("FAIL wh_ok_before_b got=%b exp=00", p_data_ok); end
        tick;
        bvalid = 1'b1;
        #1;
        total++; if (p_data_ok !== 2'b10) begin bad++; $display("FAIL wh_data_ok got=%b exp=10", p_data_ok); end
        tick;
        bvalid = 1'b0;
        p_wr = 2'b00;
    endtask
    task automatic test_round_robin;
        tick;
        p_req = 2'b11; p_wr = 2'b00; p_burst = 2'b00; p_size = 4'b1010;
        p_addr = {32'h0000_0200, 32'h0000_0100};
        for (int t = 0; t < 6; t++) begin
            #1;
            total++; if (p_addr_ok !== 2'(1 << (t % 2))) begin bad++; $display("FAIL rr%0d_grant got=%b exp=%b", t, p_addr_ok, 2'(1 << (t % 2))); end
            tick;
            #1;
            total++; if (p_addr_ok !== 2'b00) begin bad++; $display("FAIL rr%0d_ok_in_ar got=%b exp=00", t, p_addr_ok); end
            total++; if (arid !== 4'(t % 2)) begin bad++; $display("FAIL rr%0d_arid got=%0d exp=%0d", t, arid, t % 2); end
            arready = 1'b1;
            tick;
            arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'(t);
            #1;
            total++; if (p_addr_ok !== 2'b00) begin bad++; $display("FAIL rr%0d_ok_in_r got=%b exp=00", t, p_addr_ok); end
            total++; if (p_data_ok !== 2'(1 << (t % 2))) begin bad++; $display("FAIL rr%0d_data_ok got=%b exp=%b", t, p_data_ok, 2'(1 << (t % 2))); end
            tick;
            rvalid = 1'b0; rlast = 1'b0;
        end
        p_req = 2'b00;
    endtask
    task automatic test_error;
        int n = 0;
        tick;
        p_req = 2'b01; p_burst = 2'b01; p_addr[31:0] = 32'h0000_3000;
        tick;
        p_req = 2'b00;
        arready = 1'b1;
        tick;
        arready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rvalid = 1'b1; rdata = k; rlast = k == 7; rresp = k == 1 ? 2'b10 : 2'b00;
            #1;
            if (p_data_ok[0]) n++;
            if (k == 1) begin
                total++; if (axi_err !== 1'b0) begin bad++; $display("FAIL er_before got=%b exp=0", axi_err); end
            end
            if (k == 2) begin
                total++; if (axi_err !== 1'b1) begin bad++; $display("FAIL er_set got=%b exp=1", axi_err); end
            end
            tick;
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; p_burst = 2'b00;
        #1;
        total++; if (n != 8) begin bad++; $display("FAIL er_pulses got=%0d exp=8", n); end
        p_req = 2'b10; p_addr[63:32] = 32'h0000_0040;
        tick;
        p_req = 2'b00;
        arready = 1'b1;
        tick;
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1;
        #1;
        total++; if (p_data_ok !== 2'b10) begin bad++; $display("FAIL er_clean_ok got=%b exp=10", p_data_ok); end
        tick;
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        total++; if (axi_err !== 1'b1) begin bad++; $display("FAIL er_sticky got=%b exp=1", axi_err); end
    endtask
    task automatic test_reset_mid;
        tick;
        p_req = 2'b01; p_burst = 2'b01; p_addr[31:0] = 32'h0000_4000;
        tick;
        p_req = 2'b00;
        arready = 1'b1;
        tick;
        arready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rvalid = 1'b1; rdata = k; rlast = 1'b0;
            tick;
        end
        rvalid = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (rready !== 1'b1) begin bad++; $display("FAIL rm_in_r got=%b exp=1", rready); end
        tick;
        rst = 1'b0; rvalid = 1'b1;
        #1;
        total++; if (rready !== 1'b0) begin bad++; $display("FAIL rm_rready got=%b exp=0", rready); end
        total++; if (p_data_ok !== 2'b00) begin bad++; $display("FAIL rm_data_ok got=%b exp=00", p_data_ok); end
        total++; if (axi_err !== 1'b0) begin bad++; $display("FAIL rm_axi_err got=%b exp=0", axi_err); end
        total++; if ({arvalid, awvalid, wvalid, bready} !== 4'b0000) begin bad++; $display("FAIL rm_valids got=%b exp=0000", {arvalid, awvalid, wvalid, bready}); end
        rvalid = 1'b0; p_burst = 2'b00; p_req = 2'b11;
        #1;
        total++; if (p_addr_ok !== 2'b01) begin bad++; $display("FAIL rm_ptr_reset got=%b exp=01", p_addr_ok); end
        tick;
        p_req = 2'b00;
    endtask
    initial begin
        rst = 1'b1; p_req = '0; p_wr = '0; p_burst = '0; p_size = '0; p_addr = '0; p_wdata = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
        test_reset;
        test_single_read;
        test_burst_read;
        test_write;
        test_round_robin;
        test_error;
        test_reset_mid;
        tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
